// File: rtl/delay_tap_client_if.sv
// rtl/delay_tap_client_if.sv - alloc/read/write request bus between a delay tap client and the delay memory master
interface delay_tap_client_if #(
    parameter int data_width   = 16,
    parameter int size_width   = 24,
    parameter int handle_width = 5
);
    logic                           alloc_req;
    logic        [size_width-1:0]   alloc_size;
    logic        [size_width-1:0]   alloc_delay;
    logic                           read_req;
    logic        [handle_width-1:0] read_handle;
    logic signed [data_width-1:0]   read_data;
    logic                           read_valid;
    logic                           write_req;
    logic        [handle_width-1:0] write_handle;
    logic signed [data_width-1:0]   write_data;
    logic signed [data_width-1:0]   write_inc;
    logic                           write_ack;
    logic                           invalid_alloc;
    logic                           invalid_read;
    logic                           invalid_write;

    modport master (
        output alloc_req, alloc_size, alloc_delay,
        output read_req, read_handle,
        input  read_data, read_valid,
        output write_req, write_handle, write_data, write_inc,
        input  write_ack,
        input  invalid_alloc, invalid_read, invalid_write
    );

    modport slave (
        input  alloc_req, alloc_size, alloc_delay,
        input  read_req, read_handle,
        output read_data, read_valid,
        input  write_req, write_handle, write_data, write_inc,
        output write_ack,
        output invalid_alloc, invalid_read, invalid_write
    );
endinterface

// File: rtl/delay_tap_client.sv
// rtl/delay_tap_client.sv - per-slot delay line client: allocates a buffer, then reads, feeds back and mixes each sample
module delay_tap_client #(
    parameter int data_width   = 16,
    parameter int size_width   = 24,
    parameter int handle_width = 5,
    parameter int timeout      = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           cfg_start,
    input  logic        [size_width-1:0]   cfg_size,
    input  logic        [size_width-1:0]   cfg_delay,
    input  logic        [handle_width-1:0] cfg_handle,
    input  logic signed [data_width-1:0]   cfg_feedback,
    input  logic        [data_width-1:0]   cfg_mix,
    output logic                           cfg_done,
    output logic                           cfg_error,
    input  logic signed [data_width-1:0]   sample_in,
    input  logic                           sample_in_valid,
    output logic signed [data_width-1:0]   sample_out,
    output logic                           sample_out_valid,
    input  logic signed [data_width-1:0]   mod_inc,
    output logic                           busy,
    output logic                           overrun,
    output logic                           timeout_err,
    delay_tap_client_if.master             mem
);
    localparam int acc_width = 2 * data_width + 2;
    localparam int cnt_width = $clog2(timeout + 1);
    localparam logic [cnt_width-1:0]  cnt_last = cnt_width'(timeout - 1);
    localparam logic [cnt_width-1:0]  cnt_one  = cnt_width'(1);
    localparam logic [data_width-1:0] mix_one  = data_width'(16384);
    localparam logic signed [acc_width-1:0] unity = acc_width'(16384);
    localparam logic signed [acc_width-1:0] sat_max =
        $signed({{(data_width + 3){1'b0}}, {(data_width - 1){1'b1}}});
    localparam logic signed [acc_width-1:0] sat_min =
        $signed({{(data_width + 3){1'b1}}, {(data_width - 1){1'b0}}});

    typedef enum logic [2:0] {
        UNCFG, ALLOC_CHK, IDLE, READ_WAIT, WRITE_REQ, WRITE_WAIT, OUT
    } state_t;

    state_t                        state;
    logic        [cnt_width-1:0]   cnt;
    logic                          alloc_bad;
    logic        [handle_width-1:0] handle;
    logic signed [data_width-1:0]  feedback;
    logic        [data_width-1:0]  mix;
    logic signed [data_width-1:0]  wet;
    logic signed [data_width-1:0]  sample_lat;
    logic signed [data_width-1:0]  inc_lat;

    logic signed [2*data_width-1:0] fb_prod;
    logic signed [acc_width-1:0]    fb_sum;
    logic signed [acc_width-1:0]    mix_w;
    logic signed [acc_width-1:0]    mix_acc;

    function automatic logic signed [data_width-1:0] sat(input logic signed [acc_width-1:0] v);
        if (v > sat_max)      return sat_max[data_width-1:0];
        else if (v < sat_min) return sat_min[data_width-1:0];
        else                  return v[data_width-1:0];
    endfunction

    // Feedback and mix both treat 16384 as unity gain (Q1.14).
    always_comb begin
        fb_prod = (2*data_width)'(wet) * (2*data_width)'(feedback);
        fb_sum  = acc_width'(sample_lat) + acc_width'(fb_prod >>> 14);
        mix_w   = $signed({{(data_width + 2){1'b0}}, mix});
        mix_acc = (acc_width'(sample_lat) * (unity - mix_w) + acc_width'(wet) * mix_w) >>> 14;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= UNCFG;
            cnt               <= '0;
            alloc_bad         <= 1'b0;
            handle            <= '0;
            feedback          <= '0;
            mix               <= '0;
            wet               <= '0;
            sample_lat        <= '0;
            inc_lat           <= '0;
            cfg_done          <= 1'b0;
            cfg_error         <= 1'b0;
            sample_out        <= '0;
            sample_out_valid  <= 1'b0;
            busy              <= 1'b0;
            overrun           <= 1'b0;
            timeout_err       <= 1'b0;
            mem.alloc_req     <= 1'b0;
            mem.alloc_size    <= '0;
            mem.alloc_delay   <= '0;
            mem.read_req      <= 1'b0;
            mem.read_handle   <= '0;
            mem.write_req     <= 1'b0;
            mem.write_handle  <= '0;
            mem.write_data    <= '0;
            mem.write_inc     <= '0;
        end else if (enable) begin
            mem.alloc_req    <= 1'b0;
            mem.read_req     <= 1'b0;
            mem.write_req    <= 1'b0;
            cfg_error        <= 1'b0;
            sample_out_valid <= 1'b0;
            timeout_err      <= 1'b0;
            overrun          <= sample_in_valid && state != UNCFG && state != IDLE;

            if (cfg_start) begin
                handle          <= cfg_handle;
                feedback        <= cfg_feedback;
                mix             <= (cfg_mix > mix_one) ? mix_one : cfg_mix;
                mem.alloc_req   <= 1'b1;
                mem.alloc_size  <= cfg_size;
                mem.alloc_delay <= cfg_delay;
                cfg_done        <= 1'b0;
                busy            <= 1'b1;
                alloc_bad       <= 1'b0;
                cnt             <= '0;
                state           <= ALLOC_CHK;
            end else begin
                case (state)
                    UNCFG: ;
                    ALLOC_CHK: begin
                        // A reject on either of the two check cycles fails the allocation.
                        if (cnt == cnt_one) begin
                            busy <= 1'b0;
                            cnt  <= '0;
                            if (alloc_bad || mem.invalid_alloc) begin
                                cfg_error <= 1'b1;
                                state     <= UNCFG;
                            end else begin
                                cfg_done <= 1'b1;
                                state    <= IDLE;
                            end
                        end else begin
                            cnt       <= cnt + cnt_one;
                            alloc_bad <= alloc_bad || mem.invalid_alloc;
                        end
                    end
                    IDLE: begin
                        if (sample_in_valid) begin
                            sample_lat      <= sample_in;
                            inc_lat         <= mod_inc;
                            mem.read_req    <= 1'b1;
                            mem.read_handle <= handle;
                            busy            <= 1'b1;
                            cnt             <= '0;
                            state           <= READ_WAIT;
                        end
                    end
                    READ_WAIT: begin
                        if (mem.read_valid) begin
                            wet   <= mem.read_data;
                            cnt   <= '0;
                            state <= WRITE_REQ;
                        end else if (mem.invalid_read || cnt == cnt_last) begin
                            wet         <= '0;
                            timeout_err <= 1'b1;
                            cnt         <= '0;
                            state       <= WRITE_REQ;
                        end else begin
                            cnt <= cnt + cnt_one;
                        end
                    end
                    WRITE_REQ: begin
                        mem.write_req    <= 1'b1;
                        mem.write_handle <= handle;
                        mem.write_data   <= sat(fb_sum);
                        mem.write_inc    <= inc_lat;
                        cnt              <= '0;
                        state            <= WRITE_WAIT;
                    end
                    WRITE_WAIT: begin
                        if (mem.write_ack) begin
                            cnt   <= '0;
                            state <= OUT;
                        end else if (mem.invalid_write || cnt == cnt_last) begin
                            timeout_err <= 1'b1;
                            cnt         <= '0;
                            state       <= OUT;
                        end else begin
                            cnt <= cnt + cnt_one;
                        end
                    end
                    OUT: begin
                        sample_out       <= sat(mix_acc);
                        sample_out_valid <= 1'b1;
                        busy             <= 1'b0;
                        cnt              <= '0;
                        state            <= IDLE;
                    end
                    default: state <= UNCFG;
                endcase
            end
        end
    end
endmodule
